// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its
// rotate-priority picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_BURST = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from
// last_grant+1 with wrap, so last_grant itself has the lowest priority.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] winner,
    output logic               any_valid
);

    localparam int SUM_W = GRANT_W + 1;

    logic [GRANT_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi+1 positions after last_grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            assign sum          = {1'b0, last_grant} + SUM_W'(gi + 1);
            assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? GRANT_W'(sum - SUM_W'(NUM_REQ))
                                                           : GRANT_W'(sum);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner    = '0;
        any_valid = |cand_hit;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between NUM_REQ producers with round-robin,
// burst-locked grants; writes are gated on fifo_full with zero added latency.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int CNT_WIDTH  = 16,
    localparam int GRANT_W   = grant_w(NUM_REQ)
) (
    input  logic                          clkA,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          wr_count
);

    localparam int BEAT_W = grant_w(MAX_BURST);

    arb_state_e           state_reg, state_next;
    logic [GRANT_W-1:0]   grant_reg, grant_next;
    logic [GRANT_W-1:0]   last_grant_reg, last_grant_next;
    logic [BEAT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [CNT_WIDTH-1:0] wr_count_reg, wr_count_next;

    logic [GRANT_W-1:0]    winner;
    logic                  any_valid;
    logic                  in_burst;
    logic                  xfer;
    logic                  burst_done;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign in_burst   = (state_reg == BURST);
    assign xfer       = in_burst & req_valid[grant_reg] & ~fifo_full;
    assign burst_done = xfer & (req_last[grant_reg] | (beat_cnt_reg == BEAT_W'(MAX_BURST - 1)));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_word[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = in_burst & ~fifo_full & (grant_reg == GRANT_W'(gi));
        end
    endgenerate

    // Data path is a pure mux so the word reaches the FIFO in the accept cycle.
    assign fifo_wr_en   = xfer;
    assign fifo_data_in = in_burst ? req_word[grant_reg] : '0;
    assign grant_id     = grant_reg;
    assign busy         = in_burst;
    assign wr_count     = wr_count_reg;

    always_ff @(posedge clkA or posedge rst_n) begin
        if (rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GRANT_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
            wr_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            wr_count_reg   <= wr_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        wr_count_next   = wr_count_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    state_next    = BURST;
                    grant_next    = winner;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                // Grant is held while the owner is stalled or not valid.
                if (xfer) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    wr_count_next = wr_count_reg + 1'b1;
                    if (burst_done) begin
                        state_next      = IDLE;
                        last_grant_next = grant_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers feed per-requester queues,
// a negedge monitor pops expected writes whenever fifo_wr_en is seen.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int GW = grant_w(NR);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [GW-1:0] grant;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]    req_valid, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic             fifo_full, fifo_wr_en, busy;
    logic [DW-1:0]    fifo_data_in;
    logic [GW-1:0]    grant_id;
    logic [15:0]      wr_count;

    logic [1:0]    c_req_valid, c_req_last, c_req_ready;
    logic [2*DW-1:0] c_req_data;
    logic          c_fifo_full, c_fifo_wr_en, c_busy;
    logic [DW-1:0] c_fifo_data_in;
    logic [0:0]    c_grant_id;
    logic [3:0]    c_wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int cycle_no = 0;
    int base;
    word_t pq [NR][$];
    exp_t  exp_q [$];
    int    wr_cycles [$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8), .CNT_WIDTH(16)) dut (
        .clkA(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .grant_id(grant_id),
        .busy(busy), .wr_count(wr_count)
    );

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .MAX_BURST(8), .CNT_WIDTH(4)) dut_c4 (
        .clkA(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_data(c_req_data),
        .req_last(c_req_last), .req_ready(c_req_ready), .fifo_full(c_fifo_full),
        .fifo_wr_en(c_fifo_wr_en), .fifo_data_in(c_fifo_data_in), .grant_id(c_grant_id),
        .busy(c_busy), .wr_count(c_wr_count)
    );

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t mk_word(input int d, input bit last);
        word_t w;
        w.data = DW'(d);
        w.last = last;
        return w;
    endfunction

    function automatic exp_t mk_exp(input int d, input int g);
        exp_t e;
        e.data  = DW'(d);
        e.grant = GW'(g);
        return e;
    endfunction

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_writes(input int target, input string name);
        for (int k = 0; k < 200 && n_writes < target; k++) begin
            @(negedge clk);
            #1;
        end
        check_eq({name, "_write_total"}, 64'(n_writes), 64'(target));
    endtask

    // Producers: present queue heads, advance after each handshake.
    initial begin
        logic [NR-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (acc[k] && pq[k].size() > 0) void'(pq[k].pop_front());
                if (pq[k].size() > 0) begin
                    req_valid[k]           = 1'b1;
                    req_data[k*DW +: DW]   = pq[k][0].data;
                    req_last[k]            = pq[k][0].last;
                end else begin
                    req_valid[k]           = 1'b0;
                    req_data[k*DW +: DW]   = '0;
                    req_last[k]            = 1'b0;
                end
            end
        end
    end

    // Monitor: one line per write, compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (fifo_wr_en) begin
                n_writes++;
                wr_cycles.push_back(cycle_no);
                check_eq("wr_while_full", 64'(fifo_full), 64'(0));
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_write", 64'(fifo_data_in), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("write grant=%0d data=0x%08h (expect grant=%0d data=0x%08h)",
                             grant_id, fifo_data_in, e.grant, e.data);
                    check_eq("wr_data", 64'(fifo_data_in), 64'(e.data));
                    check_eq("wr_grant", 64'(grant_id), 64'(e.grant));
                end
            end
            if (busy) begin
                check_eq("hold_valid", 64'(req_valid[grant_id]), 64'(1));
                check_eq("ready_onehot", 64'(req_ready), fifo_full ? 64'(0) : 64'(1) << grant_id);
            end else begin
                check_eq("idle_quiet", {27'(0), req_ready, fifo_data_in, fifo_wr_en}, 64'(0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst_k [5];
        logic got;
        burst_k = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        fifo_full = 1'b0;
        c_fifo_full = 1'b0;
        c_req_valid = '0;
        c_req_last = '0;
        c_req_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_grant", 64'(grant_id), 64'(0));
        check_eq("rst_wr_count", 64'(wr_count), 64'(0));
        check_eq("rst_data", 64'(fifo_data_in), 64'(0));
        rst_n = 1'b0;
        sync();
        sync();

        // Test 1: three-word burst from req0
        base = n_writes;
        wr_cycles.delete();
        for (int n = 0; n < 3; n++) begin
            pq[0].push_back(mk_word(32'hA0 + n, n == 2));
            exp_q.push_back(mk_exp(32'hA0 + n, 0));
        end
        sync();
        check_eq("t1_arb_cycle_busy", 64'(busy), 64'(0));
        sync();
        check_eq("t1_grant", 64'(grant_id), 64'(0));
        check_eq("t1_busy", 64'(busy), 64'(1));
        wait_writes(base + 3, "t1");
        sync();
        check_eq("t1_idle_busy", 64'(busy), 64'(0));
        check_eq("t1_wr_count", 64'(wr_count), 64'(3));
        check_eq("t1_consecutive", 64'(wr_cycles[2] - wr_cycles[0]), 64'(2));

        rst_n = 1'b1;
        sync();
        rst_n = 1'b0;
        sync();

        // Test 2: all four valid, no last; forced re-arbitration every 8 beats
        base = n_writes;
        wr_cycles.delete();
        for (int k = 0; k < NR; k++) begin
            for (int n = 0; n < ((k == 0) ? 16 : 8); n++) pq[k].push_back(mk_word(32'h100 * k + n, 1'b0));
        end
        for (int b = 0; b < 5; b++) begin
            for (int n = 0; n < 8; n++) exp_q.push_back(mk_exp(32'h100 * burst_k[b] + ((b == 4) ? 8 : 0) + n, burst_k[b]));
        end
        wait_writes(base + 40, "t2");
        sync();
        sync();
        check_eq("t2_busy", 64'(busy), 64'(0));
        check_eq("t2_wr_count", 64'(wr_count), 64'(40));
        check_eq("t2_span_idle_gaps", 64'(wr_cycles[39] - wr_cycles[0]), 64'(43));

        // Test 3: req1 burst of 6 with fifo_full for 5 cycles after beat 2
        base = n_writes;
        for (int n = 0; n < 6; n++) begin
            pq[1].push_back(mk_word(32'hB0 + n, n == 5));
            exp_q.push_back(mk_exp(32'hB0 + n, 1));
        end
        wait_writes(base + 2, "t3_pre");
        @(posedge clk);
        #2;
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check_eq("t3_full_wr_en", 64'(fifo_wr_en), 64'(0));
            check_eq("t3_full_ready", 64'(req_ready), 64'(0));
            check_eq("t3_full_busy", 64'(busy), 64'(1));
        end
        check_eq("t3_full_wr_count", 64'(wr_count), 64'(42));
        @(posedge clk);
        #2;
        fifo_full = 1'b0;
        wait_writes(base + 6, "t3");
        sync();
        sync();
        check_eq("t3_wr_count", 64'(wr_count), 64'(46));
        check_eq("t3_busy", 64'(busy), 64'(0));

        // Test 4: reset in beat 4 of a req2 burst
        base = n_writes;
        for (int n = 0; n < 8; n++) begin
            pq[2].push_back(mk_word(32'hC0 + n, n == 7));
            exp_q.push_back(mk_exp(32'hC0 + n, 2));
        end
        wait_writes(base + 4, "t4_pre");
        @(posedge clk);
        #2;
        check_eq("t4_beat4_wr_en", 64'(fifo_wr_en), 64'(1));
        check_eq("t4_beat4_wr_count", 64'(wr_count), 64'(50));
        rst_n = 1'b1;
        #1;
        check_eq("t4_rst_wr_en", 64'(fifo_wr_en), 64'(0));
        check_eq("t4_rst_ready", 64'(req_ready), 64'(0));
        check_eq("t4_rst_busy", 64'(busy), 64'(0));
        check_eq("t4_rst_wr_count", 64'(wr_count), 64'(0));
        check_eq("t4_rst_grant", 64'(grant_id), 64'(0));
        exp_q.delete();
        pq[0].push_back(mk_word(32'hD0, 1'b0));
        pq[0].push_back(mk_word(32'hD1, 1'b1));
        pq[0].push_back(mk_word(32'hD2, 1'b0));
        pq[0].push_back(mk_word(32'hD3, 1'b1));
        pq[3].push_back(mk_word(32'hE0, 1'b0));
        pq[3].push_back(mk_word(32'hE1, 1'b1));
        exp_q.push_back(mk_exp(32'hD0, 0));
        exp_q.push_back(mk_exp(32'hD1, 0));
        for (int n = 4; n < 8; n++) exp_q.push_back(mk_exp(32'hC0 + n, 2));
        exp_q.push_back(mk_exp(32'hE0, 3));
        exp_q.push_back(mk_exp(32'hE1, 3));
        exp_q.push_back(mk_exp(32'hD2, 0));
        exp_q.push_back(mk_exp(32'hD3, 0));
        base = n_writes;
        sync();
        sync();
        rst_n = 1'b0;
        sync();
        check_eq("t4_regrant", 64'(grant_id), 64'(0));
        check_eq("t4_regrant_busy", 64'(busy), 64'(1));

        // Test 5: req2 finishes, then wrap 3 -> 0
        wait_writes(base + 10, "t5");
        sync();
        sync();
        check_eq("t5_wr_count", 64'(wr_count), 64'(10));
        check_eq("t5_busy", 64'(busy), 64'(0));
        check_eq("t5_sb_drained", 64'(exp_q.size()), 64'(0));

        // Test 6: 4-bit counter wraps after 16 single-word bursts
        for (int i = 0; i < 17; i++) begin
            c_req_data[DW-1:0] = DW'(32'hF0 + i);
            c_req_last = 2'b01;
            c_req_valid = 2'b01;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                #1;
                got = c_req_ready[0];
            end
            $display("c4 write %0d data=0x%08h wr_en=%0b", i, c_fifo_data_in, c_fifo_wr_en);
            check_eq("t6_accept", 64'(got), 64'(1));
            check_eq("t6_data", 64'(c_fifo_data_in), 64'(32'hF0 + i));
            @(posedge clk);
            #1;
            c_req_valid = 2'b00;
            if (i == 15) check_eq("t6_wrap16", 64'(c_wr_count), 64'(0));
        end
        check_eq("t6_wrap17", 64'(c_wr_count), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side controller for the asynchronous FIFO. It shares the FIFO write port (clk_w domain, driven from clkA) between NUM_REQ requesters using round-robin, burst-locked arbitration. It gates every write on fifo_full, so the FIFO never sees a write while full. It sits between producer blocks and the FIFO write interface (wr_en, data_in, full).

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, FIFO word width; must match FIFO width
MAX_BURST, 8, maximum beats per grant before forced re-arbitration (1..256)
CNT_WIDTH, 16, width of the total-writes counter

Ports:
clkA  in  1  write-domain clock (same clock as FIFO clk_w)
rst_n  in  1  reset, asynchronous, active-high (despite the name)
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  marks the final word of a requester's burst
req_ready  out  NUM_REQ  one-hot or zero; word accepted when req_valid&req_ready
fifo_full  in  1  FIFO full flag (write domain)
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DATA_WIDTH  FIFO write data
grant_id  out  clog2(NUM_REQ)  currently granted requester
busy  out  1  high while a burst is in progress
wr_count  out  CNT_WIDTH  total words written, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (asynchronous, rst_n=1):
  - state=IDLE, beat_cnt=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), wr_count=0.
  - All outputs are 0 immediately, including during a burst.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid, select the first valid requester scanning (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the winner into grant_id, set busy=1, beat_cnt=0, and go to BURST on the next edge.
  - Arbitration costs 1 cycle. No transfer happens in IDLE.
- BURST:
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en=xfer, req_ready[grant_id]=~fifo_full, and fifo_data_in = req_data slice of grant_id.
  - These are combinational: a write takes zero cycles of latency from the accept.
- Per xfer: beat_cnt++ and wr_count++ (wrap).
- Burst end: on an xfer with req_last[grant_id]=1, or with beat_cnt==MAX_BURST-1.
  - Next state IDLE, last_grant=grant_id, busy=0.
- fifo_full high in BURST: no write, req_ready=0, beat_cnt frozen. Resume the cycle full deasserts.
- Granted requester drops req_valid mid-burst: grant is held with no timeout. Producers must hold valid until last; the bench asserts this.
- Other requesters' valids are ignored during BURST; their req_ready stays 0.
- fifo_data_in is 0 whenever state==IDLE.
- Back-to-back bursts have a minimum 1 idle cycle between them (re-arbitration).

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST}
  - GRANT_W = clog2(NUM_REQ) helper
  - a default MAX_BURST constant
- Sub-module rr_arbiter: combinational rotate-priority pick.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_valid.
  - Reused by the read-side scheduler.

Test Plan:
1. Req0 sends 3 words 0xA0,0xA1,0xA2 (last on 0xA2), fifo_full=0 -> grant_id=0 one cycle after valid; wr_en high 3 consecutive cycles with the data in order; then IDLE, busy=0, wr_count=3.
2. All 4 requesters continuously valid, never last -> grant sequence 0,1,2,3,0; each grant gives exactly 8 writes with 1 idle cycle between; wr_count=40 after 5 bursts.
3. Req1 burst of 6; fifo_full forced high for 5 cycles after beat 2 -> wr_en=0 and req_ready=0 for those cycles; remaining 4 beats follow; total 6 writes, none while full.
4. Assert rst_n mid-burst (beat 4 of req2) -> fifo_wr_en, req_ready, busy, wr_count go 0 immediately; after release with req0 and req2 valid, grant goes to 0.
5. Req2 finishes; req0 and req3 valid -> next grant=3, then 0 (round-robin wrap).
6. CNT_WIDTH=4, 17 single-word bursts -> wr_count reads 1 after the 17th write.
